// File: rtl/jtdsp16_ebus_arb.sv
// jtdsp16_ebus_arb
// Arbitrates the single external ROM bus between the instruction-fetch port
// and the X-data (ROM table) port. Each access runs grant -> optional wait
// states -> data capture, with data-port priority tempered by a small
// anti-starvation counter so a busy data stream cannot lock out fetches.
// All state advances only on clock-enabled edges; reset is synchronous and
// overrides the clock enable.

module jtdsp16_ebus_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [1:0]  ws,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        dx_req,
   input  logic [15:0] dx_addr,
   input  logic [15:0] rb_din,
   output logic [15:0] ab,
   output logic        rd_n,
   output logic [15:0] rdata,
   output logic        if_ack,
   output logic        dx_ack,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Number of back-to-back data grants (taken while a fetch was pending)
   // after which the fetch port is forced through.
   localparam logic [1:0] STARVE_LIMIT = 2'd2;

   state_t      state_r, state_s;
   logic [1:0]  wcnt_r, wcnt_s;
   logic [1:0]  starve_r, starve_s;
   logic        owner_dx_r, owner_dx_s;
   logic [15:0] ab_r, ab_s;
   logic [15:0] rdata_r, rdata_s;
   logic        rd_n_r, rd_n_s;
   logic        if_ack_r, if_ack_s;
   logic        dx_ack_r, dx_ack_s;
   logic        busy_r, busy_s;

   logic        grant_if_s;
   logic        grant_dx_s;

   // Winner selection: data port first unless the fetch port has been passed over too often.
   always_comb begin
      grant_if_s = 1'b0;
      grant_dx_s = 1'b0;
      if (if_req && (!dx_req || (starve_r == STARVE_LIMIT))) begin
         grant_if_s = 1'b1;
      end else if (dx_req) begin
         grant_dx_s = 1'b1;
      end else begin
         grant_if_s = 1'b0;
         grant_dx_s = 1'b0;
      end
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_s    = state_r;
      wcnt_s     = wcnt_r;
      starve_s   = starve_r;
      owner_dx_s = owner_dx_r;
      ab_s       = ab_r;
      rdata_s    = rdata_r;
      rd_n_s     = rd_n_r;
      if_ack_s   = 1'b0;          // acks are single-cycle pulses
      dx_ack_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (grant_if_s || grant_dx_s) begin
               // Grant cycle: address and wait count are frozen here.
               owner_dx_s = grant_dx_s;
               ab_s       = grant_dx_s ? dx_addr : if_addr;
               rd_n_s     = 1'b0;
               wcnt_s     = ws;
               state_s    = (ws == 2'd0) ? ST_ACC : ST_WAIT;
               if (grant_if_s) begin
                  starve_s = 2'd0;
               end else if (if_req) begin
                  starve_s = starve_r + 2'd1;
               end else begin
                  starve_s = 2'd0;
               end
            end else begin
               rd_n_s  = 1'b1;
               state_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            wcnt_s = wcnt_r - 2'd1;
            // A zero count here cannot happen by construction; finish anyway.
            if (wcnt_r <= 2'd1) begin
               state_s = ST_ACC;
            end else begin
               state_s = ST_WAIT;
            end
         end

         ST_ACC: begin
            rdata_s  = rb_din;
            if_ack_s = !owner_dx_r;
            dx_ack_s = owner_dx_r;
            rd_n_s   = 1'b1;
            state_s  = ST_IDLE;
         end

         default: begin
            rd_n_s  = 1'b1;
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers: reset wins over cen, otherwise update on enabled edges only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wcnt_r     <= 2'd0;
         starve_r   <= 2'd0;
         owner_dx_r <= 1'b0;
         ab_r       <= 16'd0;
         rdata_r    <= 16'd0;
         rd_n_r     <= 1'b1;
         if_ack_r   <= 1'b0;
         dx_ack_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else if (cen) begin
         state_r    <= state_s;
         wcnt_r     <= wcnt_s;
         starve_r   <= starve_s;
         owner_dx_r <= owner_dx_s;
         ab_r       <= ab_s;
         rdata_r    <= rdata_s;
         rd_n_r     <= rd_n_s;
         if_ack_r   <= if_ack_s;
         dx_ack_r   <= dx_ack_s;
         busy_r     <= busy_s;
      end
   end

   assign ab     = ab_r;
   assign rd_n   = rd_n_r;
   assign rdata  = rdata_r;
   assign if_ack = if_ack_r;
   assign dx_ack = dx_ack_r;
   assign busy   = busy_r;

endmodule

// File: tb/tb_jtdsp16_ebus_arb.sv
// Directed bench for jtdsp16_ebus_arb: reset, single fetch, waited data
// access, priority/anti-starvation ordering, cen stretching and mid-access reset.

module tb_jtdsp16_ebus_arb;

   logic        clk;
   logic        rst_n;
   logic        cen;
   logic [1:0]  ws;
   logic        if_req;
   logic [15:0] if_addr;
   logic        dx_req;
   logic [15:0] dx_addr;
   logic [15:0] rb_din;
   logic [15:0] ab;
   logic        rd_n;
   logic [15:0] rdata;
   logic        if_ack;
   logic        dx_ack;
   logic        busy;

   int n_cmp;
   int n_err;

   jtdsp16_ebus_arb dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .ws      (ws),
      .if_req  (if_req),
      .if_addr (if_addr),
      .dx_req  (dx_req),
      .dx_addr (dx_addr),
      .rb_din  (rb_din),
      .ab      (ab),
      .rd_n    (rd_n),
      .rdata   (rdata),
      .if_ack  (if_ack),
      .dx_ack  (dx_ack),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected grant order with both requests held: 1 = data port, 0 = fetch port.
   logic exp_dx [6];

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      cen     = 1'b0;
      ws      = 2'd0;
      if_req  = 1'b0;
      if_addr = 16'h0000;
      dx_req  = 1'b0;
      dx_addr = 16'h0000;
      rb_din  = 16'h0000;
      exp_dx[0] = 1'b1; exp_dx[1] = 1'b1; exp_dx[2] = 1'b0;
      exp_dx[3] = 1'b1; exp_dx[4] = 1'b1; exp_dx[5] = 1'b0;

      // Reset with cen low must still clear everything.
      step();
      step();
      chk("rst_ab",    ab,              16'h0000);
      chk("rst_rd_n",  {15'd0, rd_n},   16'h0001);
      chk("rst_rdata", rdata,           16'h0000);
      chk("rst_acks",  {14'd0, if_ack, dx_ack}, 16'h0000);
      chk("rst_busy",  {15'd0, busy},   16'h0000);

      // Single fetch, no wait states.
      rst_n   = 1'b1;
      cen     = 1'b1;
      ws      = 2'd0;
      if_req  = 1'b1;
      if_addr = 16'h0123;
      rb_din  = 16'hBEEF;
      step();
      chk("f_ab",     ab,             16'h0123);
      chk("f_rd_n",   {15'd0, rd_n},  16'h0000);
      chk("f_busy",   {15'd0, busy},  16'h0001);
      chk("f_noack",  {15'd0, if_ack}, 16'h0000);
      step();
      chk("f_ack",    {15'd0, if_ack}, 16'h0001);
      chk("f_dxack",  {15'd0, dx_ack}, 16'h0000);
      chk("f_rdata",  rdata,          16'hBEEF);
      chk("f_rd_n_hi",{15'd0, rd_n},  16'h0001);
      chk("f_idle",   {15'd0, busy},  16'h0000);
      if_req = 1'b0;
      step();
      chk("f_ack_end",{15'd0, if_ack}, 16'h0000);

      // Data access with three wait states; inputs change and request drops mid-access.
      ws      = 2'd3;
      dx_req  = 1'b1;
      dx_addr = 16'h8000;
      rb_din  = 16'h1234;
      step();
      chk("d_ab",   ab,            16'h8000);
      chk("d_rd_n", {15'd0, rd_n}, 16'h0000);
      dx_addr = 16'h9000;
      ws      = 2'd0;
      dx_req  = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("d_w%0d_rd_n", i), {15'd0, rd_n},   16'h0000);
         chk($sformatf("d_w%0d_ab", i),   ab,              16'h8000);
         chk($sformatf("d_w%0d_ack", i),  {15'd0, dx_ack}, 16'h0000);
      end
      step();
      chk("d_ack",     {15'd0, dx_ack}, 16'h0001);
      chk("d_rdata",   rdata,           16'h1234);
      chk("d_rd_n_hi", {15'd0, rd_n},   16'h0001);
      step();
      chk("d_ack_end", {15'd0, dx_ack}, 16'h0000);

      // Both requests held: dx, dx, if, dx, dx, if.
      ws      = 2'd0;
      if_req  = 1'b1;
      if_addr = 16'h1111;
      dx_req  = 1'b1;
      dx_addr = 16'h2222;
      rb_din  = 16'h5555;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("p%0d_ab", i),   ab, exp_dx[i] ? 16'h2222 : 16'h1111);
         chk($sformatf("p%0d_rd_n", i), {15'd0, rd_n}, 16'h0000);
         step();
         chk($sformatf("p%0d_acks", i), {14'd0, if_ack, dx_ack},
             exp_dx[i] ? 16'h0001 : 16'h0002);
      end
      if_req = 1'b0;
      dx_req = 1'b0;
      step();
      chk("p_acks_end", {14'd0, if_ack, dx_ack}, 16'h0000);

      // cen toggling with one wait state: each cycle stretched to two clocks.
      ws      = 2'd1;
      if_req  = 1'b1;
      if_addr = 16'h4321;
      rb_din  = 16'hA5A5;
      cen     = 1'b1;
      step();
      chk("c_ab",      ab,            16'h4321);
      chk("c_rd_n",    {15'd0, rd_n}, 16'h0000);
      cen = 1'b0;
      step();
      chk("c_hold_rd", {15'd0, rd_n}, 16'h0000);
      chk("c_hold_bz", {15'd0, busy}, 16'h0001);
      cen = 1'b1;
      step();
      chk("c_wait_ack", {15'd0, if_ack}, 16'h0000);
      cen = 1'b0;
      step();
      chk("c_wait2_ack",{15'd0, if_ack}, 16'h0000);
      chk("c_wait2_rd", {15'd0, rd_n},   16'h0000);
      cen = 1'b1;
      step();
      chk("c_ack",     {15'd0, if_ack}, 16'h0001);
      chk("c_rdata",   rdata,           16'hA5A5);
      if_req = 1'b0;
      cen    = 1'b0;
      step();
      chk("c_ack_2clk",{15'd0, if_ack}, 16'h0001);
      cen = 1'b1;
      step();
      chk("c_ack_end", {15'd0, if_ack}, 16'h0000);

      // Reset during WAIT aborts with no ack; a fresh request afterwards completes.
      ws      = 2'd2;
      dx_req  = 1'b1;
      dx_addr = 16'h3333;
      step();
      chk("r_ab",   ab,            16'h3333);
      chk("r_busy", {15'd0, busy}, 16'h0001);
      step();
      chk("r_wait_busy", {15'd0, busy}, 16'h0001);
      rst_n  = 1'b0;
      dx_req = 1'b0;
      step();
      chk("r_rd_n", {15'd0, rd_n}, 16'h0001);
      chk("r_ab0",  ab,            16'h0000);
      chk("r_busy0",{15'd0, busy}, 16'h0000);
      rst_n = 1'b1;
      step();
      chk("r_noack", {14'd0, if_ack, dx_ack}, 16'h0000);
      chk("r_idle",  {15'd0, busy},           16'h0000);
      ws      = 2'd0;
      if_req  = 1'b1;
      if_addr = 16'h0777;
      rb_din  = 16'h0F0F;
      step();
      chk("r2_ab",   ab,            16'h0777);
      chk("r2_rd_n", {15'd0, rd_n}, 16'h0000);
      if_req = 1'b0;
      step();
      chk("r2_ack",   {15'd0, if_ack}, 16'h0001);
      chk("r2_rdata", rdata,           16'h0F0F);
      step();
      chk("r2_ack_end", {15'd0, if_ack}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jtdsp16_ebus_arb.md
JTDSP16_EBUS_ARB -- requirements
Module: jtdsp16_ebus_arb

Interface
REQ-001 clk  input  1  system clock; all flops on rising edge.
REQ-002 rst_n  input  1  reset: one clock, synchronous, active-low.
REQ-003 cen  input  1  clock enable (CPU cen/2 rate); state advances only when cen=1.
REQ-004 ws  input  2  wait states per external access, 0..3.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-006 if_addr  input  16  instruction-fetch address.
REQ-007 dx_req  input  1  X-data (ROM table) request, held high until dx_ack.
REQ-008 dx_addr  input  16  X-data address.
REQ-009 rb_din  input  16  external ROM data bus.
REQ-010 ab  output  16  external address bus.
REQ-011 rd_n  output  1  external read strobe, active-low.
REQ-012 rdata  output  16  data returned for the last completed access.
REQ-013 if_ack  output  1  fetch access complete, rdata valid.
REQ-014 dx_ack  output  1  data access complete, rdata valid.
REQ-015 busy  output  1  high while an access is in progress (state != IDLE).

Function
REQ-016 All registers SHALL hold their value whenever cen=0; "cycle" below means a clk edge with cen=1.
REQ-017 FSM states SHALL be IDLE, ACC and WAIT.
REQ-018 IDLE with no request: ab holds its last value, rd_n=1, state stays IDLE.
REQ-019 IDLE with a request (grant cycle): arbiter SHALL select the winner, latch its address into ab, drive rd_n=0, load wait counter with ws, and go to ACC if ws=0, else WAIT.
REQ-020 WAIT: counter SHALL decrement by 1 each cycle and move to ACC in the cycle it reaches 0 from 1.
REQ-021 ACC: arbiter SHALL register rb_din into rdata, pulse the winner's ack, drive rd_n=1, and return to IDLE.
REQ-022 Access latency SHALL be ws+2 cycles from grant cycle to ack; consecutive accesses have one IDLE cycle between them.
REQ-023 Each ack SHALL be high for exactly one cen period; at most one ack is high at any time.
REQ-024 Priority: dx_req SHALL win over if_req.
REQ-025 Anti-starvation: a 2-bit counter SHALL count consecutive dx grants made while if_req was high; at count 2 the next grant SHALL go to if_req even if dx_req is high; any if grant clears the counter.
REQ-026 A dx grant made while if_req is low SHALL clear the starvation counter.
REQ-027 ws, if_addr and dx_addr SHALL be sampled only in the grant cycle; later changes do not affect the running access.
REQ-028 A request dropped mid-access SHALL not abort the access; its ack still pulses.
REQ-029 A request still high in the ack cycle SHALL be treated as a new request at the next IDLE cycle.
REQ-030 busy SHALL be 1 in ACC and WAIT and 0 in IDLE.

Reset
REQ-031 While rst_n=0 at a clk edge, regardless of cen: state=IDLE, ab=0, rd_n=1, rdata=0, if_ack=0, dx_ack=0, busy=0, wait and starvation counters=0.
REQ-032 Reset during WAIT or ACC SHALL abort the access with no ack pulse.
REQ-033 The first grant may occur on the first cycle after rst_n returns high.

Verification
REQ-034 ws=0, if_req=1, if_addr=16'h0123, rb_din=16'hBEEF -> ab=0123 and rd_n=0 after the grant cycle; if_ack pulses 2 cycles after grant with rdata=BEEF; rd_n=1.
REQ-035 ws=3, dx_req=1, dx_addr=16'h8000 -> rd_n low for 4 cycles; dx_ack after 5 cycles; dx_addr changed to 16'h9000 mid-access leaves ab=8000.
REQ-036 if_req and dx_req held high continuously, ws=0 -> grant order dx, dx, if, dx, dx, if; never two acks at once.
REQ-037 cen toggling 1/0 with ws=1 -> identical grant and ack sequence to cen=1, each cycle stretched to 2 clocks; ack lasts 2 clocks.
REQ-038 rst_n=0 for one clk during WAIT (ws=2) -> no ack; rd_n=1, ab=0, busy=0 next edge; fresh request after release completes normally.
